// File: rtl/pipe_front_regs_pkg.sv
// Shared constants for the front-end pipeline registers: bubble instruction,
// default reset PC, default control-bundle width and event-counter width.
package pipe_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          CTRL_W_DEF   = 16;
    localparam int          CNT_W        = 16;

endpackage : pipe_pkg

// File: rtl/pipe_front_regs_if.sv
// Hazard-unit control bundle for the front-end pipeline registers.
// The hazard unit drives every signal (master); the register block only
// samples them on the rising clock edge (slave). There is no ready/back-
// pressure path: each enable/stall/flush level is sampled once per edge and
// takes effect on that edge only.
interface pipe_front_regs_if;

    logic PC_EN_IF;
    logic reg_FD_EN;
    logic reg_FD_stall;
    logic reg_FD_flush;
    logic reg_DE_EN;
    logic reg_DE_flush;
    logic clr_cnt;

    modport master (
        output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, clr_cnt
    );

    modport slave (
        input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush,
               reg_DE_EN, reg_DE_flush, clr_cnt
    );

endinterface : pipe_front_regs_if

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with hazard controls, stall/flush
// event counters and a sticky flag for the illegal stall+flush combination.
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CTRL_W   = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_front_regs_if.slave  hz,
    input  logic [31:0]       next_pc,
    input  logic [31:0]       inst_IF,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [4:0]        rd_ID,
    input  logic [4:0]        rs1_ID,
    input  logic [4:0]        rs2_ID,
    input  logic [31:0]       rs1_data_ID,
    input  logic [31:0]       rs2_data_ID,
    input  logic [31:0]       imm_ID,
    output logic [31:0]       PC_IF,
    output logic [31:0]       PC_ID,
    output logic [31:0]       inst_ID,
    output logic              valid_ID,
    output logic [31:0]       PC_EXE,
    output logic [CTRL_W-1:0] ctrl_EXE,
    output logic [4:0]        rd_EXE,
    output logic [4:0]        rs1_EXE,
    output logic [4:0]        rs2_EXE,
    output logic [31:0]       rs1_data_EXE,
    output logic [31:0]       rs2_data_EXE,
    output logic [31:0]       imm_EXE,
    output logic              valid_EXE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              protocol_err
);

    // Decoded per-edge actions. A stall on IF/ID overrides a flush there.
    logic fd_stall_act;
    logic fd_flush_act;
    logic de_flush_act;
    logic flush_evt;

    assign fd_stall_act = hz.reg_FD_EN && hz.reg_FD_stall;
    assign fd_flush_act = hz.reg_FD_EN && !hz.reg_FD_stall && hz.reg_FD_flush;
    assign de_flush_act = hz.reg_DE_EN && hz.reg_DE_flush;
    // Simultaneous IF/ID and ID/EX flushes still count as a single event.
    assign flush_evt    = fd_flush_act || de_flush_act;

    // Fetch PC: load when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_IF <= RESET_PC;
        end else if (hz.PC_EN_IF) begin
            PC_IF <= next_pc;
        end
    end

    // IF/ID: disabled or stalled holds, flush inserts a NOP bubble, else load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_ID    <= '0;
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end else if (hz.reg_FD_EN && !hz.reg_FD_stall) begin
            if (hz.reg_FD_flush) begin
                PC_ID    <= '0;
                inst_ID  <= NOP_INST;
                valid_ID <= 1'b0;
            end else begin
                PC_ID    <= PC_IF;
                inst_ID  <= inst_IF;
                valid_ID <= 1'b1;
            end
        end
    end

    // ID/EX: disabled holds, flush inserts an all-zero bubble, else load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_EXE       <= '0;
            ctrl_EXE     <= '0;
            rd_EXE       <= '0;
            rs1_EXE      <= '0;
            rs2_EXE      <= '0;
            rs1_data_EXE <= '0;
            rs2_data_EXE <= '0;
            imm_EXE      <= '0;
            valid_EXE    <= 1'b0;
        end else if (hz.reg_DE_EN) begin
            if (hz.reg_DE_flush) begin
                PC_EXE       <= '0;
                ctrl_EXE     <= '0;
                rd_EXE       <= '0;
                rs1_EXE      <= '0;
                rs2_EXE      <= '0;
                rs1_data_EXE <= '0;
                rs2_data_EXE <= '0;
                imm_EXE      <= '0;
                valid_EXE    <= 1'b0;
            end else begin
                PC_EXE       <= PC_ID;
                ctrl_EXE     <= ctrl_ID;
                rd_EXE       <= rd_ID;
                rs1_EXE      <= rs1_ID;
                rs2_EXE      <= rs2_ID;
                rs1_data_EXE <= rs1_data_ID;
                rs2_data_EXE <= rs2_data_ID;
                imm_EXE      <= imm_ID;
                valid_EXE    <= valid_ID;
            end
        end
    end

    // Sticky flag: hazard unit asked for stall and flush on IF/ID at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (hz.reg_FD_stall && hz.reg_FD_flush) begin
            protocol_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (hz.clr_cnt),
        .inc   (fd_stall_act),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (hz.clr_cnt),
        .inc   (flush_evt),
        .count (flush_cnt)
    );

endmodule : pipe_front_regs

// File: tb/tb_pipe_front_regs.sv
// Directed, table-driven bench for pipe_front_regs plus hand-written
// sequences for counter saturation, sticky error and asynchronous reset.
module tb_pipe_front_regs;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0000_0093;
    localparam logic [31:0] I1  = 32'h0020_8133;
    localparam logic [31:0] I2  = 32'h0000_0213;
    localparam logic [31:0] I3  = 32'h0000_0313;
    localparam logic [31:0] I4  = 32'h0000_0413;
    localparam logic [31:0] I5  = 32'h0000_0513;
    localparam logic [31:0] I6  = 32'h0000_0613;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] inst_IF;
    logic [15:0] ctrl_ID;
    logic [4:0]  rd_ID, rs1_ID, rs2_ID;
    logic [31:0] rs1_data_ID, rs2_data_ID, imm_ID;
    logic [31:0] PC_IF, PC_ID, inst_ID, PC_EXE;
    logic        valid_ID, valid_EXE;
    logic [15:0] ctrl_EXE;
    logic [4:0]  rd_EXE, rs1_EXE, rs2_EXE;
    logic [31:0] rs1_data_EXE, rs2_data_EXE, imm_EXE;
    logic [15:0] stall_cnt, flush_cnt;
    logic        protocol_err;

    int n_vec;
    int n_bad;

    pipe_front_regs_if hz ();

    pipe_front_regs dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hz.slave),
        .next_pc      (next_pc),
        .inst_IF      (inst_IF),
        .ctrl_ID      (ctrl_ID),
        .rd_ID        (rd_ID),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rs1_data_ID  (rs1_data_ID),
        .rs2_data_ID  (rs2_data_ID),
        .imm_ID       (imm_ID),
        .PC_IF        (PC_IF),
        .PC_ID        (PC_ID),
        .inst_ID      (inst_ID),
        .valid_ID     (valid_ID),
        .PC_EXE       (PC_EXE),
        .ctrl_EXE     (ctrl_EXE),
        .rd_EXE       (rd_EXE),
        .rs1_EXE      (rs1_EXE),
        .rs2_EXE      (rs2_EXE),
        .rs1_data_EXE (rs1_data_EXE),
        .rs2_data_EXE (rs2_data_EXE),
        .imm_EXE      (imm_EXE),
        .valid_EXE    (valid_EXE),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .protocol_err (protocol_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pc_en, fd_en, fd_stall, fd_flush, de_en, de_flush, clr;
        logic [31:0] next_pc;
        logic [31:0] inst_if;
        logic [15:0] tag;
        logic [31:0] e_pc_if, e_pc_id, e_inst_id;
        logic        e_vid, e_vexe, e_live;
        logic [15:0] e_ctrl;
        logic [31:0] e_pc_exe;
        logic [15:0] e_stall, e_flush;
        logic        e_perr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_ctl(input logic pc_en, input logic fd_en, input logic fd_stall,
                             input logic fd_flush, input logic de_en, input logic de_flush,
                             input logic clr);
        hz.PC_EN_IF     = pc_en;
        hz.reg_FD_EN    = fd_en;
        hz.reg_FD_stall = fd_stall;
        hz.reg_FD_flush = fd_flush;
        hz.reg_DE_EN    = de_en;
        hz.reg_DE_flush = de_flush;
        hz.clr_cnt      = clr;
    endtask

    // ID-stage operands are tagged so their arrival in EXE is traceable.
    task automatic drive_id(input logic [15:0] tag);
        ctrl_ID     = tag;
        rd_ID       = tag[4:0];
        rs1_ID      = tag[9:5];
        rs2_ID      = tag[14:10];
        rs1_data_ID = {16'h1111, tag};
        rs2_data_ID = {16'h2222, tag};
        imm_ID      = {16'h3333, tag};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_pc_if"},   PC_IF, 32'h0);
        chk({pfx, "_pc_id"},   PC_ID, 32'h0);
        chk({pfx, "_inst_id"}, inst_ID, NOP);
        chk({pfx, "_valid_id"}, {31'b0, valid_ID}, 32'h0);
        chk({pfx, "_valid_exe"}, {31'b0, valid_EXE}, 32'h0);
        chk({pfx, "_ctrl_exe"}, {16'b0, ctrl_EXE}, 32'h0);
        chk({pfx, "_imm_exe"}, imm_EXE, 32'h0);
        chk({pfx, "_pc_exe"},  PC_EXE, 32'h0);
        chk({pfx, "_stall_cnt"}, {16'b0, stall_cnt}, 32'h0);
        chk({pfx, "_flush_cnt"}, {16'b0, flush_cnt}, 32'h0);
        chk({pfx, "_perr"}, {31'b0, protocol_err}, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // pc fd st fl de df clr  next_pc       inst  tag      | pc_if         pc_id          inst vid vexe live ctrl     pc_exe         stall  flush  perr
        tbl[0]  = '{1,1,0,0,1,0,0, 32'h4,        I0, 16'h0000, 32'h4,   32'h0,   I0,  1,0,1, 16'h0000, 32'h0,   16'd0, 16'd0, 0};
        tbl[1]  = '{1,1,0,0,1,0,0, 32'h8,        I1, 16'h0A01, 32'h8,   32'h4,   I1,  1,1,1, 16'h0A01, 32'h0,   16'd0, 16'd0, 0};
        tbl[2]  = '{0,1,1,0,1,1,0, 32'hC,        I2, 16'h0B01, 32'h8,   32'h4,   I1,  1,0,0, 16'h0000, 32'h0,   16'd1, 16'd1, 0};
        tbl[3]  = '{1,1,0,0,1,0,0, 32'hC,        I2, 16'h0B01, 32'hC,   32'h8,   I2,  1,1,1, 16'h0B01, 32'h4,   16'd1, 16'd1, 0};
        tbl[4]  = '{1,1,0,1,1,0,0, 32'h100,      I3, 16'h0C02, 32'h100, 32'h0,   NOP, 0,1,1, 16'h0C02, 32'h8,   16'd1, 16'd2, 0};
        tbl[5]  = '{1,1,0,0,1,0,0, 32'h104,      I4, 16'h0000, 32'h104, 32'h100, I4,  1,0,1, 16'h0000, 32'h0,   16'd1, 16'd2, 0};
        tbl[6]  = '{0,0,0,1,0,1,0, 32'hDEC,      I5, 16'h0D04, 32'h104, 32'h100, I4,  1,0,1, 16'h0000, 32'h0,   16'd1, 16'd2, 0};
        tbl[7]  = '{0,1,1,1,1,0,0, 32'hDEC,      I5, 16'h0D04, 32'h104, 32'h100, I4,  1,1,1, 16'h0D04, 32'h100, 16'd2, 16'd2, 1};
        tbl[8]  = '{1,1,0,0,1,0,0, 32'h108,      I5, 16'h0D04, 32'h108, 32'h104, I5,  1,1,1, 16'h0D04, 32'h100, 16'd2, 16'd2, 1};
        tbl[9]  = '{1,1,0,0,1,1,0, 32'h10C,      I6, 16'h0E05, 32'h10C, 32'h108, I6,  1,0,0, 16'h0000, 32'h0,   16'd2, 16'd3, 1};
        tbl[10] = '{1,1,0,1,1,1,0, 32'h200,      I3, 16'h0F06, 32'h200, 32'h0,   NOP, 0,0,0, 16'h0000, 32'h0,   16'd2, 16'd4, 1};
        tbl[11] = '{0,1,1,0,1,0,1, 32'hDEC,      I3, 16'h0000, 32'h200, 32'h0,   NOP, 0,0,1, 16'h0000, 32'h0,   16'd0, 16'd0, 1};

        // Reset block
        rst = 1'b1;
        drive_ctl(0, 0, 0, 0, 0, 0, 0);
        next_pc = '0;
        inst_IF = '0;
        drive_id(16'h0000);
        repeat (2) tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            drive_ctl(tbl[i].pc_en, tbl[i].fd_en, tbl[i].fd_stall, tbl[i].fd_flush,
                      tbl[i].de_en, tbl[i].de_flush, tbl[i].clr);
            next_pc = tbl[i].next_pc;
            inst_IF = tbl[i].inst_if;
            drive_id(tbl[i].tag);
            tick();
            chk($sformatf("v%0d_pc_if", i),   PC_IF,   tbl[i].e_pc_if);
            chk($sformatf("v%0d_pc_id", i),   PC_ID,   tbl[i].e_pc_id);
            chk($sformatf("v%0d_inst_id", i), inst_ID, tbl[i].e_inst_id);
            chk($sformatf("v%0d_valid_id", i),  {31'b0, valid_ID},  {31'b0, tbl[i].e_vid});
            chk($sformatf("v%0d_valid_exe", i), {31'b0, valid_EXE}, {31'b0, tbl[i].e_vexe});
            chk($sformatf("v%0d_ctrl_exe", i), {16'b0, ctrl_EXE}, {16'b0, tbl[i].e_ctrl});
            chk($sformatf("v%0d_rd_exe", i),  {27'b0, rd_EXE},  tbl[i].e_live ? {27'b0, tbl[i].e_ctrl[4:0]}   : 32'h0);
            chk($sformatf("v%0d_rs1_exe", i), {27'b0, rs1_EXE}, tbl[i].e_live ? {27'b0, tbl[i].e_ctrl[9:5]}   : 32'h0);
            chk($sformatf("v%0d_rs2_exe", i), {27'b0, rs2_EXE}, tbl[i].e_live ? {27'b0, tbl[i].e_ctrl[14:10]} : 32'h0);
            chk($sformatf("v%0d_rs1_data", i), rs1_data_EXE, tbl[i].e_live ? {16'h1111, tbl[i].e_ctrl} : 32'h0);
            chk($sformatf("v%0d_rs2_data", i), rs2_data_EXE, tbl[i].e_live ? {16'h2222, tbl[i].e_ctrl} : 32'h0);
            chk($sformatf("v%0d_imm_exe", i),  imm_EXE,      tbl[i].e_live ? {16'h3333, tbl[i].e_ctrl} : 32'h0);
            chk($sformatf("v%0d_pc_exe", i),   PC_EXE,  tbl[i].e_pc_exe);
            chk($sformatf("v%0d_stall_cnt", i), {16'b0, stall_cnt}, {16'b0, tbl[i].e_stall});
            chk($sformatf("v%0d_flush_cnt", i), {16'b0, flush_cnt}, {16'b0, tbl[i].e_flush});
            chk($sformatf("v%0d_perr", i), {31'b0, protocol_err}, {31'b0, tbl[i].e_perr});
        end

        // Long stall: stall counter saturates, flush counter untouched.
        drive_ctl(0, 1, 1, 0, 1, 0, 0);
        drive_id(16'h0000);
        repeat (70000) tick();
        chk("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);
        chk("sat_flush_cnt", {16'b0, flush_cnt}, 32'h0);
        chk("sat_pc_if", PC_IF, 32'h200);

        // Clear beats increment while stall is still asserted.
        hz.clr_cnt = 1'b1;
        tick();
        chk("clr_stall_cnt", {16'b0, stall_cnt}, 32'h0);
        hz.clr_cnt = 1'b0;
        repeat (3) tick();
        chk("post_clr_stall_cnt", {16'b0, stall_cnt}, 32'd3);
        chk("perr_sticky", {31'b0, protocol_err}, 32'h1);

        // Asynchronous reset between edges, mid-stall.
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        chk_reset_vals("rst_held");
        #2;
        rst = 1'b0;
        drive_ctl(1, 1, 0, 0, 1, 0, 0);
        next_pc = 32'h4;
        inst_IF = I0;
        tick();
        chk("post_rst_pc_if", PC_IF, 32'h4);
        chk("post_rst_pc_id", PC_ID, 32'h0);
        chk("post_rst_inst_id", inst_ID, I0);
        chk("post_rst_valid_id", {31'b0, valid_ID}, 32'h1);
        chk("post_rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("post_rst_perr", {31'b0, protocol_err}, 32'h0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pipe_front_regs
